// File: rtl/wb_dest_pipe.sv
// wb_dest_pipe: write-back destination pipeline with register hazard detection.
// Tracks DEPTH in-flight destination addresses from selection to write-back,
// and flags pending writes that match the decode-stage read addresses.
// Optional build macro: WB_DEST_R0_SUPPRESS_EN (address 0 never written,
// counted or flagged as a hazard).
module wb_dest_pipe #(
   parameter int ADDR_W = 4,
   parameter int NSRC   = 4,
   parameter int DEPTH  = 3
) (
   input  logic                     clk,
   input  logic                     rst_f,
   input  logic [NSRC*ADDR_W-1:0]   src_addr,
   input  logic [2:0]               sel,
   input  logic                     wr_en_in,
   input  logic                     stall,
   input  logic                     flush,
   input  logic [ADDR_W-1:0]        rd_addr_a,
   input  logic [ADDR_W-1:0]        rd_addr_b,
   output logic [ADDR_W-1:0]        dest_out,
   output logic                     wr_en_out,
   output logic                     hazard_a,
   output logic                     hazard_b,
   output logic [3:0]               pend_cnt
);

   logic [ADDR_W-1:0] addr [DEPTH];
   logic [DEPTH-1:0]  v;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_ok;
   logic              new_v;

   // Pick the candidate address; out-of-range selects yield address 0.
   always_comb begin
      sel_addr = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (32'(sel) == i) sel_addr = src_addr[i*ADDR_W +: ADDR_W];
      end
   end

   // Stage-0 valid: writing instruction with a legal source.
   always_comb begin
      sel_ok = (32'(sel) < NSRC);
`ifdef WB_DEST_R0_SUPPRESS_EN
      new_v  = wr_en_in & sel_ok & (sel_addr != '0);
`else
      new_v  = wr_en_in & sel_ok;
`endif
   end

   // Pipeline shift on unstalled edges; flush clears all but the committing stage.
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         for (int k = 0; k < DEPTH; k++) addr[k] <= '0;
         v <= '0;
      end else begin
         if (!stall) begin
            addr[0] <= sel_ok ? sel_addr : '0;
            v[0]    <= new_v;
            for (int k = 1; k < DEPTH; k++) begin
               addr[k] <= addr[k-1];
               v[k]    <= v[k-1];
            end
         end
         if (flush) begin
            for (int k = 0; k < DEPTH-1; k++) v[k] <= 1'b0;
         end
      end
   end

   // Final-stage outputs; a stalled entry only strobes once stall drops.
   always_comb begin
      dest_out  = addr[DEPTH-1];
      wr_en_out = v[DEPTH-1] & ~stall;
   end

   // Hazard match against every valid stage, plus valid-stage population count.
   always_comb begin
      hazard_a = 1'b0;
      hazard_b = 1'b0;
      pend_cnt = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (v[k] && (addr[k] == rd_addr_a)) hazard_a = 1'b1;
         if (v[k] && (addr[k] == rd_addr_b)) hazard_b = 1'b1;
         pend_cnt = pend_cnt + 4'(v[k]);
      end
`ifdef WB_DEST_R0_SUPPRESS_EN
      if (rd_addr_a == '0) hazard_a = 1'b0;
      if (rd_addr_b == '0) hazard_b = 1'b0;
`endif
   end

endmodule

// File: tb/tb_wb_dest_pipe.sv
// Testbench for wb_dest_pipe: directed scenarios plus randomized traffic,
// checked against a list-of-in-flight-instructions reference model.
module tb_wb_dest_pipe;
   localparam int ADDR_W = 4;
   localparam int NSRC   = 4;
   localparam int DEPTH  = 3;

   logic                   clk = 1'b0;
   logic                   rst_f = 1'b0;
   logic [NSRC*ADDR_W-1:0] src_addr = '0;
   logic [2:0]             sel = '0;
   logic                   wr_en_in = 1'b0;
   logic                   stall = 1'b0;
   logic                   flush = 1'b0;
   logic [ADDR_W-1:0]      rd_addr_a = '0;
   logic [ADDR_W-1:0]      rd_addr_b = '0;
   logic [ADDR_W-1:0]      dest_out;
   logic                   wr_en_out;
   logic                   hazard_a;
   logic                   hazard_b;
   logic [3:0]             pend_cnt;

   wb_dest_pipe #(.ADDR_W(ADDR_W), .NSRC(NSRC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_f(rst_f), .src_addr(src_addr), .sel(sel),
      .wr_en_in(wr_en_in), .stall(stall), .flush(flush),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .dest_out(dest_out), .wr_en_out(wr_en_out),
      .hazard_a(hazard_a), .hazard_b(hazard_b), .pend_cnt(pend_cnt)
   );

   always #5 clk = ~clk;

   // An in-flight instruction: its destination and how many stages it has advanced.
   typedef struct {
      logic [ADDR_W-1:0] a;
      int                pos;
   } ent_t;

   ent_t              inflight[$];
   logic [ADDR_W-1:0] exp_q[$];
   int                checks = 0;
   int                errors = 0;
   int                writes_seen = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic bit model_hazard(input logic [ADDR_W-1:0] rd);
      bit h = 0;
`ifdef WB_DEST_R0_SUPPRESS_EN
      if (rd == '0) return 0;
`endif
      foreach (inflight[i]) if (inflight[i].a == rd) h = 1;
      return h;
   endfunction

   // Advance the reference model by one clock edge using the inputs held at that edge.
   task automatic model_edge();
      ent_t nxt[$];
      ent_t e;
      int   s;
      bit   nv;
      nxt = {};
      foreach (inflight[i]) begin
         e = inflight[i];
         if (!stall) e.pos++;
         if (e.pos < DEPTH && !(flush && e.pos <= DEPTH-2)) begin
            nxt.push_back(e);
            if (!stall && e.pos == DEPTH-1) exp_q.push_back(e.a);
         end
      end
      s = int'(sel);
      nv = wr_en_in && (s < NSRC);
      if (nv) e.a = src_addr[s*ADDR_W +: ADDR_W];
`ifdef WB_DEST_R0_SUPPRESS_EN
      if (nv && e.a == '0) nv = 0;
`endif
      if (!stall && nv) begin
         e.pos = 0;
         if (!(flush && 0 <= DEPTH-2)) begin
            nxt.push_back(e);
            if (DEPTH == 1) exp_q.push_back(e.a);
         end
      end
      inflight = nxt;
   endtask

   task automatic check_comb();
      check("pend_cnt", int'(pend_cnt), inflight.size());
      check("hazard_a", int'(hazard_a), int'(model_hazard(rd_addr_a)));
      check("hazard_b", int'(hazard_b), int'(model_hazard(rd_addr_b)));
   endtask

   // Drive inputs shortly after a rising edge, check combinational outputs, then take the next edge.
   task automatic step(input bit st, input bit fl, input bit we, input logic [2:0] s,
                       input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb);
      stall = st; flush = fl; wr_en_in = we; sel = s;
      rd_addr_a = ra; rd_addr_b = rb;
      #1;
      check_comb();
      @(posedge clk);
      if (rst_f) model_edge();
      #1;
   endtask

   // Monitor: at each falling edge a write is due iff the model has an entry parked
   // in the final stage and the pipe is not stalled.
   always @(negedge clk) begin
      bit due;
      due = rst_f && !stall && (exp_q.size() > 0);
      check("wr_en_out", int'(wr_en_out), int'(due));
      if (wr_en_out && exp_q.size() > 0) begin
         check("dest_out", int'(dest_out), int'(exp_q[0]));
         void'(exp_q.pop_front());
         writes_seen++;
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_dest"},  int'(dest_out), 0);
      check({tag, "_wr"},    int'(wr_en_out), 0);
      check({tag, "_haz_a"}, int'(hazard_a), 0);
      check({tag, "_haz_b"}, int'(hazard_b), 0);
      check({tag, "_pend"},  int'(pend_cnt), 0);
   endtask

   initial begin
      int w0;
      logic [ADDR_W-1:0] ra;
      // Reset held: outputs must be zero even with stimulus applied.
      src_addr = {4'hC, 4'h9, 4'h5, 4'h2};
      wr_en_in = 1'b1; sel = 3'd1; rd_addr_a = 4'h0; rd_addr_b = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("in_reset");
      rst_f = 1'b1;
      wr_en_in = 1'b0;
      @(posedge clk); #1;

      // Basic: sel=2 -> address 9 written three edges later, one pending for three cycles.
      w0 = writes_seen;
      step(0, 0, 1, 3'd2, 4'h9, 4'h6);
      check("basic_pend1", int'(pend_cnt), 1);
      repeat (5) step(0, 0, 0, 3'd0, 4'h9, 4'h6);
      check("basic_writes", writes_seen - w0, 1);

      // Hazard: address 5 (sel=1), read ports 5 and 6.
      step(0, 0, 1, 3'd1, 4'h5, 4'h6);
      repeat (4) step(0, 0, 0, 3'd0, 4'h5, 4'h6);

      // Stall while the entry sits in the final stage: one write after release.
      w0 = writes_seen;
      step(0, 0, 1, 3'd3, 4'hC, 4'h0);
      step(0, 0, 0, 3'd0, 4'hC, 4'h0);
      step(0, 0, 0, 3'd0, 4'hC, 4'h0);
      step(1, 0, 0, 3'd0, 4'hC, 4'h0);
      step(1, 0, 0, 3'd0, 4'hC, 4'h0);
      repeat (3) step(0, 0, 0, 3'd0, 4'hC, 4'h0);
      check("stall_writes", writes_seen - w0, 1);

      // Flush: A,B,C back to back, flush on C's issue edge -> only A written.
      w0 = writes_seen;
      step(0, 0, 1, 3'd0, 4'h2, 4'h5);
      step(0, 0, 1, 3'd1, 4'h2, 4'h5);
      step(0, 1, 1, 3'd2, 4'h2, 4'h5);
      check("flush_pend", int'(pend_cnt), 1);
      repeat (4) step(0, 0, 0, 3'd0, 4'h2, 4'h5);
      check("flush_writes", writes_seen - w0, 1);

      // Out-of-range select never enters the pipe.
      step(0, 0, 1, 3'd5, 4'h0, 4'h0);
      check("sel_oor_pend", int'(pend_cnt), 0);
      step(0, 0, 0, 3'd0, 4'h0, 4'h0);

      // Address 0 issue: suppressed or ordinary depending on build.
      src_addr = {4'hC, 4'h0, 4'h5, 4'h2};
      step(0, 0, 1, 3'd2, 4'h0, 4'h0);
      repeat (4) step(0, 0, 0, 3'd0, 4'h0, 4'h0);

      // Mid-cycle reset with three valid entries.
      src_addr = {4'hC, 4'h9, 4'h5, 4'h2};
      step(0, 0, 1, 3'd0, 4'h2, 4'h5);
      step(0, 0, 1, 3'd1, 4'h2, 4'h5);
      step(0, 0, 1, 3'd3, 4'h2, 4'h5);
      wr_en_in = 1'b0;
      #1;
      check("pre_reset_pend", int'(pend_cnt), 3);
      #1;
      rst_f = 1'b0;
      #1;
      check_all_zero("mid_reset");
      inflight = {};
      exp_q = {};
      @(posedge clk); #1;
      check_all_zero("reset_held");
      rst_f = 1'b1;
      repeat (4) step(0, 0, 0, 3'd0, 4'h2, 4'hC);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         src_addr = NSRC*ADDR_W'($urandom);
         ra = ADDR_W'($urandom);
         if (inflight.size() > 0 && $urandom_range(0, 1) == 1)
            ra = inflight[$urandom_range(0, inflight.size()-1)].a;
         step($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)),
              ra, ADDR_W'($urandom));
      end
      repeat (DEPTH + 2) step(0, 0, 0, 3'd0, 4'h0, 4'h0);
      check("exp_q_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_dest_pipe.md
WB_DEST_PIPE -- requirements
Module: wb_dest_pipe

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, the register-address width.
REQ-002 SHALL have parameter NSRC, default 4, the number of candidate destination sources (legal range 2..8).
REQ-003 SHALL have parameter DEPTH, default 3, the number of pipeline stages between selection and write-back (legal range 1..8).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_f, input, 1 bit, the reset: asynchronous and active-low.
REQ-006 SHALL have port src_addr, input, NSRC*ADDR_W bits, the candidate addresses; source i occupies bits [i*ADDR_W +: ADDR_W].
REQ-007 SHALL have port sel, input, 3 bits, the source index.
REQ-008 SHALL have port wr_en_in, input, 1 bit, which marks the issuing instruction as writing a register.
REQ-009 SHALL have port stall, input, 1 bit, which holds all stages.
REQ-010 SHALL have port flush, input, 1 bit, which squashes younger stages.
REQ-011 SHALL have ports rd_addr_a and rd_addr_b, inputs, ADDR_W bits each, the decode-stage read addresses.
REQ-012 SHALL have port dest_out, output, ADDR_W bits, the write-back address from the final stage.
REQ-013 SHALL have port wr_en_out, output, 1 bit, the register-file write strobe.
REQ-014 SHALL have ports hazard_a and hazard_b, outputs, 1 bit each, which flag pending writes to rd_addr_a and rd_addr_b.
REQ-015 SHALL have port pend_cnt, output, 4 bits, the count of valid stages.

Function
REQ-016 SHALL hold per stage k (0..DEPTH-1) a registered address addr[k] and a valid bit v[k].
REQ-017 When stall=0, each edge SHALL load stage 0 with src_addr[sel] and v[0]=wr_en_in, and stage k with stage k-1 for k>=1.
REQ-018 If sel>=NSRC, stage 0 SHALL load addr=0 with v[0]=0.
REQ-019 When stall=1 and flush=0, all stages SHALL hold their values.
REQ-020 When flush=1, v[0..DEPTH-2] SHALL clear on the edge, regardless of stall.
REQ-021 Under flush with stall=0, stage DEPTH-1 SHALL still load from stage DEPTH-2; under flush with stall=1, stage DEPTH-1 SHALL hold. Flush never squashes the stage being committed.
REQ-022 dest_out SHALL equal addr[DEPTH-1].
REQ-023 wr_en_out SHALL equal v[DEPTH-1] AND NOT stall, so a stalled instruction writes exactly once.
REQ-024 The latency from issue to wr_en_out SHALL be DEPTH unstalled cycles.
REQ-025 hazard_a SHALL be combinational: 1 iff some k has v[k]=1 and addr[k]=rd_addr_a; hazard_b is the same for rd_addr_b.
REQ-026 pend_cnt SHALL be the combinational population count of v[], in the range 0..DEPTH.
REQ-027 With DEPTH=1, flush SHALL have no effect on state.

Reset
REQ-028 rst_f=0 SHALL immediately clear all addr[k] and v[k], independent of clk.
REQ-029 While rst_f=0, the outputs SHALL be dest_out=0, wr_en_out=0, hazard_a=hazard_b=0, pend_cnt=0.
REQ-030 On release, the first capture SHALL be the first rising clk edge with rst_f=1.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight entries with no write strobe issued.

Configuration
REQ-032 SHALL honour the macro WB_DEST_R0_SUPPRESS_EN.
REQ-033 With WB_DEST_R0_SUPPRESS_EN defined, a selected address of 0 SHALL load v[0]=0, so R0 is never written or counted.
REQ-034 With WB_DEST_R0_SUPPRESS_EN defined, hazard_a and hazard_b SHALL never assert when the read address is 0.
REQ-035 Without the macro, address 0 SHALL be treated like any other address.

Verification
REQ-036 Scenario basic: DEPTH=3, src_addr={4'hC,4'h9,4'h5,4'h2}, sel=2, wr_en_in=1 pulsed one cycle -> wr_en_out=1 with dest_out=9 exactly 3 edges later; pend_cnt reads 1 for 3 cycles.
REQ-037 Scenario hazard: addr 5 issued, rd_addr_a=5, rd_addr_b=6 -> hazard_a=1 and hazard_b=0 from edge 1 through edge 3, both 0 afterwards.
REQ-038 Scenario stall: stall=1 for 2 cycles while the entry sits in the final stage -> wr_en_out=0 during the stall, then a single 1-cycle pulse after release.
REQ-039 Scenario flush: issue A,B,C back-to-back, flush at the edge when C is in stage 0 -> only A is written, B and C are squashed, pend_cnt=1 after the edge.
REQ-040 Scenario sel out of range: sel=5 with NSRC=4, wr_en_in=1 -> no write, pend_cnt stays 0.
REQ-041 Scenario reset: rst_f driven low mid-cycle with 3 valid entries -> all outputs 0 immediately and no wr_en_out after release; with the macro defined, an issue to address 0 yields no write and no hazard.
